mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Multi-cycle control FSM for the MIPS core. It decodes Op/Funct from the latched instruction and sequences every ALU use, including PC+4, branch-target add and compare. It drives the ALU's ALUOp and operand selects, and consumes the ALU's Zero flag to resolve branches. It replaces the single-cycle combinational controller when the datapath moves to the shared-ALU, shared-memory multi-cycle organisation.

Parameters:
OP_W, 6, width of Op and Funct fields
ALUOP_W, 4, width of ALUOp; values are the `ALU_* macros in ctrl_encode_def.v

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
Op  in  6  instr[31:26], valid from DECODE onward (IR latched)
Funct  in  6  instr[5:0]
Zero  in  1  ALU zero flag, combinational from current ALU result
PCWr  out  1  PC load enable
IorD  out  1  memory address: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
RegWrite  out  1  register file write
RegDst  out  2  00 rt, 01 rd, 10 $31
WDSel  out  2  00 ALUOut, 01 MDR, 10 PC
EXTOp  out  1  1 sign-extend, 0 zero-extend imm16
ALUSrcA  out  3  000 PC, 001 rs, 010 shamt, 011 const 16, 100 rt
ALUSrcB  out  3  000 rt, 001 const 4, 010 ext imm, 011 ext imm<<2, 100 shamt
PCSource  out  2  00 ALU C, 01 ALUOut, 10 {PC[31:28],instr[25:0],2'b00}, 11 rs
ALUOp  out  4  ALU operation
Illegal  out  1  sticky undefined-instruction flag

Behaviour:
- Reset:
  - rst=1 forces state to S_RST asynchronously.
  - In S_RST all outputs are 0, ALUOp = `ALU_NOP.
  - Next edge after rst falls goes to FETCH.
  - rst mid-instruction aborts it; no partial write occurs after rst asserts.
- Outputs are decoded from the state register (plus Op/Funct). The only Mealy term is PCWr in BRANCH.
- Unlisted outputs are 0 in each state. ALUOp defaults to `ALU_NOP.
- FETCH:
  - MemRead, IorD=0, IRWrite, ALUSrcA=000, ALUSrcB=001, ALUOp=ADD, PCSource=00, PCWr=1.
  - Next state DECODE.
- DECODE:
  - Branch target: ALUSrcA=000, ALUSrcB=011, EXTOp=1, ALUOp=ADD (result to ALUOut).
  - Dispatch on Op:
    - lw/sw (100011/101011) -> MEMADR
    - R-type (000000) -> REXEC, or JR if Funct=001000
    - addi/andi/ori/slti/lui -> IEXEC
    - beq/bne -> BRANCH
    - j -> JUMP
    - jal -> JAL
    - other -> ILLEGAL
- MEMADR:
  - ALUSrcA=001, ALUSrcB=010, EXTOp=1, ALUOp=ADD.
  - Next state MEMRD (lw) or MEMWR (sw).
- MEMRD: MemRead, IorD=1. Next MEMWB.
- MEMWB: RegWrite, RegDst=00, WDSel=01. Next FETCH.
- MEMWR: MemWrite, IorD=1. Next FETCH.
- REXEC (Funct -> ALUOp):
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT, 101011 SLTU: A=001, B=000.
  - 000000 SLL: A=010, B=000.
  - 000010 SRL: A=100, B=100.
  - Other Funct -> ILLEGAL instead of RWB.
  - Next RWB.
- RWB: RegWrite, RegDst=01, WDSel=00. Next FETCH.
- IEXEC:
  - addi: ADD, EXTOp=1.
  - andi: AND, EXTOp=0.
  - ori: OR, EXTOp=0.
  - slti: SLT, EXTOp=1.
  - All of the above: A=001, B=010.
  - lui: SLL, A=011, B=010, EXTOp=0.
  - Next IWB.
- IWB: RegWrite, RegDst=00, WDSel=00. Next FETCH.
- BRANCH:
  - A=001, B=000, ALUOp=SUB, PCSource=01.
  - PCWr = Zero for beq, ~Zero for bne.
  - Next FETCH.
- JUMP: PCSource=10, PCWr=1. Next FETCH.
- JAL:
  - RegWrite, RegDst=10, WDSel=10 (PC already +4), PCSource=10, PCWr=1.
  - Next FETCH.
- JR: PCSource=11, PCWr=1. Next FETCH.
- ILLEGAL:
  - Illegal=1, all strobes 0.
  - Stays until rst.
- Instruction latencies in cycles, FETCH included:
  - lw 5
  - R, I, sw 4
  - beq/bne, j, jal, jr 3
- Zero is sampled only in BRANCH. Zero in other states has no effect.

Test Plan:
- Reset: rst pulse mid-MEMRD -> all outputs 0 immediately; after release, S_RST then FETCH with MemRead=1, IRWrite=1, PCWr=1, ALUOp=`ALU_ADD.
- lw: Op=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. MEMADR shows ALUSrcB=010, EXTOp=1. MEMWB shows RegWrite=1, WDSel=01. Back in FETCH on cycle 6.
- R-type sweep: every legal Funct -> correct ALUOp in REXEC. SRL shows ALUSrcA=100, ALUSrcB=100. Funct=111111 -> ILLEGAL; Illegal stays 1 across 10 cycles until rst.
- beq/bne: Op=000100 with Zero=1 -> PCWr=1, PCSource=01 in BRANCH. Same with Zero=0 -> PCWr=0. Op=000101 gives the inverted result. Zero toggled in other states never changes PCWr.
- jal: Op=000011 -> JAL with RegDst=10, WDSel=10, PCSource=10, RegWrite=1, PCWr=1, all in one cycle; 3-cycle total.
- lui: Op=001111 -> IEXEC with ALUOp=`ALU_SLL, ALUSrcA=011, EXTOp=0, then IWB with RegWrite=1, RegDst=00.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM; decodes latched Op/Funct and sequences the shared ALU and memory.
// 3-5 cycles per instruction, outputs registered from next state; no backpressure, only PCWr in BRANCH follows Zero live.
`ifndef ALU_NOP
`define ALU_NOP  4'b0000
`define ALU_ADD  4'b0001
`define ALU_SUB  4'b0010
`define ALU_AND  4'b0011
`define ALU_OR   4'b0100
`define ALU_NOR  4'b0101
`define ALU_SLT  4'b0110
`define ALU_SLTU 4'b0111
`define ALU_SLL  4'b1000
`define ALU_SRL  4'b1001
`endif

module mc_ctrl #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    Op,
  input  logic [OP_W-1:0]    Funct,
  input  logic               Zero,
  output logic               PCWr,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         WDSel,
  output logic               EXTOp,
  output logic [2:0]         ALUSrcA,
  output logic [2:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               Illegal
);

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

  localparam logic [OP_W-1:0] F_ADD  = 6'b100000;
  localparam logic [OP_W-1:0] F_SUB  = 6'b100010;
  localparam logic [OP_W-1:0] F_AND  = 6'b100100;
  localparam logic [OP_W-1:0] F_OR   = 6'b100101;
  localparam logic [OP_W-1:0] F_NOR  = 6'b100111;
  localparam logic [OP_W-1:0] F_SLT  = 6'b101010;
  localparam logic [OP_W-1:0] F_SLTU = 6'b101011;
  localparam logic [OP_W-1:0] F_SLL  = 6'b000000;
  localparam logic [OP_W-1:0] F_SRL  = 6'b000010;
  localparam logic [OP_W-1:0] F_JR   = 6'b001000;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_REXEC,
    S_RWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_ILLEGAL
  } state_t;

  typedef struct packed {
    logic               pcwr;
    logic               iord;
    logic               memread;
    logic               memwrite;
    logic               irwrite;
    logic               regwrite;
    logic [1:0]         regdst;
    logic [1:0]         wdsel;
    logic               extop;
    logic [2:0]         srca;
    logic [2:0]         srcb;
    logic [1:0]         pcsrc;
    logic [ALUOP_W-1:0] aluop;
    logic               illegal;
  } ctl_t;

  state_t state, nxt;
  ctl_t   ctl;

  function automatic logic r_legal(logic [OP_W-1:0] fn);
    case (fn)
      F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT, F_SLTU, F_SLL, F_SRL: r_legal = 1'b1;
      default: r_legal = 1'b0;
    endcase
  endfunction

  function automatic ctl_t decode(state_t s, logic [OP_W-1:0] op, logic [OP_W-1:0] fn);
    ctl_t c;
    c = '0;
    c.aluop = `ALU_NOP;
    case (s)
      S_FETCH: begin
        c.memread = 1'b1; c.irwrite = 1'b1; c.srcb = 3'b001;
        c.aluop = `ALU_ADD; c.pcwr = 1'b1;
      end
      S_DECODE: begin
        c.srcb = 3'b011; c.extop = 1'b1; c.aluop = `ALU_ADD;
      end
      S_MEMADR: begin
        c.srca = 3'b001; c.srcb = 3'b010; c.extop = 1'b1; c.aluop = `ALU_ADD;
      end
      S_MEMRD: begin c.memread = 1'b1; c.iord = 1'b1; end
      S_MEMWB: begin c.regwrite = 1'b1; c.wdsel = 2'b01; end
      S_MEMWR: begin c.memwrite = 1'b1; c.iord = 1'b1; end
      S_REXEC: begin
        c.srca = 3'b001;
        case (fn)
          F_ADD:  c.aluop = `ALU_ADD;
          F_SUB:  c.aluop = `ALU_SUB;
          F_AND:  c.aluop = `ALU_AND;
          F_OR:   c.aluop = `ALU_OR;
          F_NOR:  c.aluop = `ALU_NOR;
          F_SLT:  c.aluop = `ALU_SLT;
          F_SLTU: c.aluop = `ALU_SLTU;
          F_SLL:  begin c.aluop = `ALU_SLL; c.srca = 3'b010; end
          F_SRL:  begin c.aluop = `ALU_SRL; c.srca = 3'b100; c.srcb = 3'b100; end
          default: c.srca = 3'b000;
        endcase
      end
      S_RWB: begin c.regwrite = 1'b1; c.regdst = 2'b01; end
      S_IEXEC: begin
        c.srca = 3'b001; c.srcb = 3'b010;
        case (op)
          OP_ADDI: begin c.aluop = `ALU_ADD; c.extop = 1'b1; end
          OP_ANDI: c.aluop = `ALU_AND;
          OP_ORI:  c.aluop = `ALU_OR;
          OP_SLTI: begin c.aluop = `ALU_SLT; c.extop = 1'b1; end
          OP_LUI:  begin c.aluop = `ALU_SLL; c.srca = 3'b011; end
          default: ;
        endcase
      end
      S_IWB: c.regwrite = 1'b1;
      S_BRANCH: begin c.srca = 3'b001; c.aluop = `ALU_SUB; c.pcsrc = 2'b01; end
      S_JUMP: begin c.pcsrc = 2'b10; c.pcwr = 1'b1; end
      S_JAL: begin
        c.regwrite = 1'b1; c.regdst = 2'b10; c.wdsel = 2'b10;
        c.pcsrc = 2'b10; c.pcwr = 1'b1;
      end
      S_JR: begin c.pcsrc = 2'b11; c.pcwr = 1'b1; end
      S_ILLEGAL: c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_RST:    nxt = S_FETCH;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW:                             nxt = S_MEMADR;
          OP_RTYPE:                                 nxt = (Funct == F_JR) ? S_JR : S_REXEC;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: nxt = S_IEXEC;
          OP_BEQ, OP_BNE:                           nxt = S_BRANCH;
          OP_J:                                     nxt = S_JUMP;
          OP_JAL:                                   nxt = S_JAL;
          default:                                  nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  nxt = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   nxt = S_MEMWB;
      S_REXEC:   nxt = r_legal(Funct) ? S_RWB : S_ILLEGAL;
      S_IEXEC:   nxt = S_IWB;
      S_ILLEGAL: nxt = S_ILLEGAL;
      default:   nxt = S_FETCH;
    endcase
  end

  // Registering decode(nxt) keeps outputs glitch-free; Op/Funct are stable from DECODE onward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_RST;
      ctl       <= '0;
      ctl.aluop <= `ALU_NOP;
    end else begin
      state <= nxt;
      ctl   <= decode(nxt, Op, Funct);
    end
  end

  assign PCWr     = ctl.pcwr | ((state == S_BRANCH) & ((Op == OP_BNE) ? ~Zero : Zero));
  assign IorD     = ctl.iord;
  assign MemRead  = ctl.memread;
  assign MemWrite = ctl.memwrite;
  assign IRWrite  = ctl.irwrite;
  assign RegWrite = ctl.regwrite;
  assign RegDst   = ctl.regdst;
  assign WDSel    = ctl.wdsel;
  assign EXTOp    = ctl.extop;
  assign ALUSrcA  = ctl.srca;
  assign ALUSrcB  = ctl.srcb;
  assign PCSource = ctl.pcsrc;
  assign ALUOp    = ctl.aluop;
  assign Illegal  = ctl.illegal;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: vector table, hand-written corner sequences and a random instruction stream
// checked cycle by cycle against a per-instruction trace model.
module tb_mc_ctrl;

  localparam logic [3:0] A_NOP = 4'd0, A_ADD = 4'd1, A_SUB = 4'd2, A_AND = 4'd3, A_OR = 4'd4,
                         A_NOR = 4'd5, A_SLT = 4'd6, A_SLTU = 4'd7, A_SLL = 4'd8, A_SRL = 4'd9;

  logic clk = 1'b0, rst = 1'b1, Zero = 1'b0;
  logic [5:0] Op = '0, Funct = '0;
  logic PCWr, IorD, MemRead, MemWrite, IRWrite, RegWrite, EXTOp, Illegal;
  logic [1:0] RegDst, WDSel, PCSource;
  logic [2:0] ALUSrcA, ALUSrcB;
  logic [3:0] ALUOp;

  mc_ctrl #(.OP_W(6), .ALUOP_W(4)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWr(PCWr), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .WDSel(WDSel), .EXTOp(EXTOp), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcwr, iord, memread, memwrite, irwrite, regwrite;
    logic [1:0] regdst, wdsel;
    logic extop;
    logic [2:0] srca, srcb;
    logic [1:0] pcsrc;
    logic [3:0] aluop;
    logic illegal;
  } outs_t;

  typedef struct {
    logic [5:0] op, fn;
    int lat;
    logic [3:0] aop;
    logic [2:0] sa, sb;
    logic ext;
  } vec_t;

  int tests = 0, fails = 0;
  vec_t vt[$];
  outs_t exp_q[$];
  bit zs[8];
  logic [5:0] good_ops[12], bad_ops[4], r_fns[10];
  logic [5:0] rop, rfn, bop;
  logic bz, bexp;
  int cyc, lat, r;

  function automatic outs_t act();
    return '{PCWr, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, WDSel, EXTOp,
             ALUSrcA, ALUSrcB, PCSource, ALUOp, Illegal};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  function automatic outs_t o0();
    outs_t o = '0;
    o.aluop = A_NOP;
    return o;
  endfunction

  function automatic outs_t fetch_o();
    outs_t o = o0();
    o.memread = 1; o.irwrite = 1; o.srcb = 3'b001; o.aluop = A_ADD; o.pcwr = 1;
    return o;
  endfunction

  function automatic void add_vec(logic [5:0] op, logic [5:0] fn, int l, logic [3:0] aop,
                                  logic [2:0] sa, logic [2:0] sb, logic ext);
    vec_t v;
    v.op = op; v.fn = fn; v.lat = l; v.aop = aop; v.sa = sa; v.sb = sb; v.ext = ext;
    vt.push_back(v);
  endfunction

  // Expected per-cycle outputs of one instruction, starting at its FETCH cycle.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, output bit ill);
    outs_t o;
    ill = 0;
    exp_q.delete();
    exp_q.push_back(fetch_o());
    o = o0(); o.srcb = 3'b011; o.extop = 1; o.aluop = A_ADD; exp_q.push_back(o);
    o = o0();
    case (op)
      6'h23, 6'h2b: begin
        o.srca = 1; o.srcb = 2; o.extop = 1; o.aluop = A_ADD; exp_q.push_back(o);
        o = o0();
        if (op == 6'h23) begin
          o.memread = 1; o.iord = 1; exp_q.push_back(o);
          o = o0(); o.regwrite = 1; o.wdsel = 2'b01; exp_q.push_back(o);
        end else begin
          o.memwrite = 1; o.iord = 1; exp_q.push_back(o);
        end
      end
      6'h00: begin
        if (fn == 6'h08) begin
          o.pcsrc = 2'b11; o.pcwr = 1; exp_q.push_back(o);
        end else begin
          o.srca = 1;
          case (fn)
            6'h20: o.aluop = A_ADD;  6'h22: o.aluop = A_SUB;  6'h24: o.aluop = A_AND;
            6'h25: o.aluop = A_OR;   6'h27: o.aluop = A_NOR;  6'h2a: o.aluop = A_SLT;
            6'h2b: o.aluop = A_SLTU;
            6'h00: begin o.aluop = A_SLL; o.srca = 2; end
            6'h02: begin o.aluop = A_SRL; o.srca = 4; o.srcb = 4; end
            default: begin o = o0(); ill = 1; end
          endcase
          exp_q.push_back(o);
          if (!ill) begin o = o0(); o.regwrite = 1; o.regdst = 2'b01; exp_q.push_back(o); end
        end
      end
      6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h0f: begin
        o.srca = 1; o.srcb = 2;
        if (op == 6'h08) begin o.aluop = A_ADD; o.extop = 1; end
        if (op == 6'h0c) o.aluop = A_AND;
        if (op == 6'h0d) o.aluop = A_OR;
        if (op == 6'h0a) begin o.aluop = A_SLT; o.extop = 1; end
        if (op == 6'h0f) begin o.aluop = A_SLL; o.srca = 3; end
        exp_q.push_back(o);
        o = o0(); o.regwrite = 1; exp_q.push_back(o);
      end
      6'h04, 6'h05: begin
        o.srca = 1; o.aluop = A_SUB; o.pcsrc = 2'b01;
        o.pcwr = (op == 6'h04) ? zs[2] : !zs[2];
        exp_q.push_back(o);
      end
      6'h02: begin o.pcsrc = 2'b10; o.pcwr = 1; exp_q.push_back(o); end
      6'h03: begin
        o.regwrite = 1; o.regdst = 2'b10; o.wdsel = 2'b10; o.pcsrc = 2'b10; o.pcwr = 1;
        exp_q.push_back(o);
      end
      default: ill = 1;
    endcase
    if (ill) begin
      o = o0(); o.illegal = 1;
      repeat (3) exp_q.push_back(o);
    end
  endtask

  // Asserts rst asynchronously, checks the reset state, then the FETCH that follows.
  // Leaves the bench at the FETCH-cycle negedge.
  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    #1 chk("rst async", act(), o0());
    @(posedge clk); #1 rst = 0;
    @(negedge clk); chk("s_rst", act(), o0());
    @(negedge clk); chk("fetch after rst", act(), fetch_o());
  endtask

  // Entered and left at a FETCH-cycle negedge.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
    bit ill;
    build(op, fn, ill);
    Op = op; Funct = fn;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      Zero = zs[i];
      #1 chk($sformatf("trace op=%h fn=%h cyc=%0d", op, fn, i), act(), exp_q[i]);
    end
    if (ill) do_reset();
    else begin @(posedge clk); @(negedge clk); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    good_ops = '{6'h23, 6'h2b, 6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h0f, 6'h04, 6'h05, 6'h02, 6'h03};
    bad_ops  = '{6'h01, 6'h06, 6'h3f, 6'h20};
    r_fns    = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h08};

    add_vec(6'h23, 6'h00, 5, A_ADD,  3'd1, 3'd2, 1'b1);
    add_vec(6'h2b, 6'h00, 4, A_ADD,  3'd1, 3'd2, 1'b1);
    add_vec(6'h00, 6'h20, 4, A_ADD,  3'd1, 3'd0, 1'b0);
    add_vec(6'h00, 6'h22, 4, A_SUB,  3'd1, 3'd0, 1'b0);
    add_vec(6'h00, 6'h24, 4, A_AND,  3'd1, 3'd0, 1'b0);
    add_vec(6'h00, 6'h25, 4, A_OR,   3'd1, 3'd0, 1'b0);
    add_vec(6'h00, 6'h27, 4, A_NOR,  3'd1, 3'd0, 1'b0);
    add_vec(6'h00, 6'h2a, 4, A_SLT,  3'd1, 3'd0, 1'b0);
    add_vec(6'h00, 6'h2b, 4, A_SLTU, 3'd1, 3'd0, 1'b0);
    add_vec(6'h00, 6'h00, 4, A_SLL,  3'd2, 3'd0, 1'b0);
    add_vec(6'h00, 6'h02, 4, A_SRL,  3'd4, 3'd4, 1'b0);
    add_vec(6'h00, 6'h08, 3, A_NOP,  3'd0, 3'd0, 1'b0);
    add_vec(6'h08, 6'h00, 4, A_ADD,  3'd1, 3'd2, 1'b1);
    add_vec(6'h0c, 6'h00, 4, A_AND,  3'd1, 3'd2, 1'b0);
    add_vec(6'h0d, 6'h00, 4, A_OR,   3'd1, 3'd2, 1'b0);
    add_vec(6'h0a, 6'h00, 4, A_SLT,  3'd1, 3'd2, 1'b1);
    add_vec(6'h0f, 6'h00, 4, A_SLL,  3'd3, 3'd2, 1'b0);
    add_vec(6'h04, 6'h00, 3, A_SUB,  3'd1, 3'd0, 1'b0);
    add_vec(6'h05, 6'h00, 3, A_SUB,  3'd1, 3'd0, 1'b0);
    add_vec(6'h02, 6'h00, 3, A_NOP,  3'd0, 3'd0, 1'b0);
    add_vec(6'h03, 6'h00, 3, A_NOP,  3'd0, 3'd0, 1'b0);

    #3 chk("reset state", act(), o0());
    do_reset();

    // Vector table: third-cycle ALU controls and instruction latency.
    foreach (vt[v]) begin
      Op = vt[v].op; Funct = vt[v].fn; Zero = 0;
      cyc = 1; lat = -1;
      while (cyc < 12 && lat < 0) begin
        @(posedge clk); @(negedge clk); cyc++;
        if (cyc == 3)
          chk($sformatf("vec%0d exec ctl", v), {ALUOp, ALUSrcA, ALUSrcB, EXTOp},
              {vt[v].aop, vt[v].sa, vt[v].sb, vt[v].ext});
        if (IRWrite) lat = cyc - 1;
      end
      chk($sformatf("vec%0d latency", v), lat, vt[v].lat);
    end

    // Branch resolution: Zero matters only in BRANCH, and live within it.
    for (int k = 0; k < 4; k++) begin
      bop = (k >= 2) ? 6'h05 : 6'h04;
      bz = (k % 2) == 1;
      bexp = (bop == 6'h04) ? bz : !bz;
      Op = bop; Funct = 0; Zero = !bz;
      @(posedge clk); #1 Zero = bz; #1 chk("decode pcwr", PCWr, 1'b0);
      Zero = !bz; #1 chk("decode pcwr zflip", PCWr, 1'b0);
      @(posedge clk); #1 Zero = bz; #1 chk("branch pcwr", {PCWr, PCSource}, {bexp, 2'b01});
      Zero = !bz; #1 chk("branch pcwr zflip", PCWr, !bexp);
      @(posedge clk); #1 Zero = bz; #1 chk("fetch pcwr", PCWr, 1'b1);
      @(negedge clk);
    end

    // Undefined Funct parks in ILLEGAL until reset.
    Op = 6'h00; Funct = 6'h3f;
    repeat (3) @(posedge clk);
    repeat (10) begin
      @(negedge clk);
      chk("illegal sticky", {Illegal, MemRead, MemWrite, RegWrite, PCWr, IRWrite}, 6'b100000);
      @(posedge clk);
    end
    do_reset();

    // Reset in the middle of a load: nothing of the load survives.
    Op = 6'h23; Funct = 0; Zero = 0;
    repeat (3) @(posedge clk);
    #1 chk("memrd before rst", {MemRead, IorD}, 2'b11);
    rst = 1;
    #1 chk("rst mid memrd", act(), o0());
    @(posedge clk); #1 rst = 0;
    @(negedge clk); chk("s_rst after abort", act(), o0());
    @(negedge clk); chk("fetch after abort", act(), fetch_o());

    // Every opcode and R-type Funct once, then a random stream.
    foreach (good_ops[i]) begin
      for (int z = 0; z < 8; z++) zs[z] = 1'($urandom);
      run_instr(good_ops[i], 6'h20);
    end
    foreach (r_fns[i]) begin
      for (int z = 0; z < 8; z++) zs[z] = 1'($urandom);
      run_instr(6'h00, r_fns[i]);
    end
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        rop = bad_ops[$urandom_range(0, 3)];
        rfn = 6'($urandom);
      end else begin
        rop = good_ops[$urandom_range(0, 11)];
        rfn = (r < 11) ? 6'h3f : r_fns[$urandom_range(0, 9)];
      end
      for (int z = 0; z < 8; z++) zs[z] = 1'($urandom);
      run_instr(rop, rfn);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
